// File: rtl/multi_strobe_timer.sv
// ---------------------------------------------------------------------------
// multi_strobe_timer
//   NUM_CH independent strobe channels driven from one clock. Each channel
//   has its own runtime-programmable period P and mode:
//     0 toggle   : o_out inverts at every terminal count (period 2(P+1))
//     1 pulse    : o_out mirrors o_tick
//     2 one-shot : first terminal sets o_out/o_done, then the channel stops
//     3 reserved : behaves as toggle
//   A terminal count occurs every P+1 enabled cycles.
//
//   Optional build macro MULTI_STROBE_TIMER_SHADOW_EN: writes go to a
//   per-channel shadow register and are transferred to the active period and
//   mode at the next terminal count, or straight away if the channel is
//   disabled or stopped. Without the macro a write takes effect on the next
//   clock and restarts the channel.
//
// Ports:
//   i_clk        system clock, rising-edge
//   i_rst_n      asynchronous active-low reset
//   i_en         per-channel run enable
//   i_wr_stb     write strobe qualifying the i_wr_* buses
//   i_wr_ch      channel index for the write (out-of-range indices ignored)
//   i_wr_period  new period P
//   i_wr_mode    new mode
//   o_out        per-channel strobe output
//   o_tick       one-cycle pulse following each terminal count
//   o_done       sticky one-shot completion flag
// ---------------------------------------------------------------------------
module multi_strobe_timer #(
  parameter int               NUM_CH         = 4,
  parameter int               CNT_W          = 32,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(50_000_000),
  parameter logic [1:0]       DEFAULT_MODE   = 2'd0,
  localparam int              CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_wr_stb,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [CNT_W-1:0]  i_wr_period,
  input  logic [1:0]        i_wr_mode,
  output logic [NUM_CH-1:0] o_out,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_done
);

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [1:0]       mode_q, mode_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             en_prev_q;
    logic             wr_hit;
    logic             en_rise;
    logic             stopped;
`ifdef MULTI_STROBE_TIMER_SHADOW_EN
    logic [CNT_W-1:0] shadow_period_q, shadow_period_d;
    logic [1:0]       shadow_mode_q, shadow_mode_d;
    logic             pend_q, pend_d;
`endif

    // Decoding against each channel's own index makes out-of-range writes
    // fall through without a separate bounds check.
    assign wr_hit  = i_wr_stb && (i_wr_ch == CH_W'(gi));
    assign en_rise = i_en[gi] && !en_prev_q;
    // A completed one-shot parks until re-armed.
    assign stopped = (mode_q == 2'd2) && done_q;

    always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      mode_d   = mode_q;
      out_d    = out_q;
      tick_d   = 1'b0;
      done_d   = done_q;
`ifdef MULTI_STROBE_TIMER_SHADOW_EN
      shadow_period_d = shadow_period_q;
      shadow_mode_d   = shadow_mode_q;
      pend_d          = pend_q;
`endif

      if (!i_en[gi]) begin
        cnt_d = '0;
        if (mode_q == 2'd1) out_d = 1'b0;
      end else if ((mode_q == 2'd2) && en_rise) begin
        // Re-arm the one-shot on an enable rising edge.
        cnt_d  = '0;
        out_d  = 1'b0;
        done_d = 1'b0;
      end else if (stopped) begin
        cnt_d = '0;
      end else if (cnt_q == period_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (mode_q)
          2'd1: out_d = 1'b1;
          2'd2: begin
            out_d  = 1'b1;
            done_d = 1'b1;
          end
          default: out_d = ~out_q;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mode_q == 2'd1) out_d = 1'b0;
      end

`ifdef MULTI_STROBE_TIMER_SHADOW_EN
      // tick_d doubles as "terminal this cycle" for the transfer decision.
      if (wr_hit) begin
        shadow_period_d = i_wr_period;
        shadow_mode_d   = i_wr_mode;
        pend_d          = 1'b1;
      end else if (pend_q && (!i_en[gi] || stopped || tick_d)) begin
        period_d = shadow_period_q;
        mode_d   = shadow_mode_q;
        pend_d   = 1'b0;
        cnt_d    = '0;
        if (stopped) begin
          out_d  = 1'b0;
          done_d = 1'b0;
        end
      end
`else
      // A write overrides everything, including a coincident terminal.
      if (wr_hit) begin
        period_d = i_wr_period;
        mode_d   = i_wr_mode;
        cnt_d    = '0;
        out_d    = 1'b0;
        tick_d   = 1'b0;
        done_d   = 1'b0;
      end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q     <= '0;
        period_q  <= DEFAULT_PERIOD;
        mode_q    <= DEFAULT_MODE;
        out_q     <= 1'b0;
        tick_q    <= 1'b0;
        done_q    <= 1'b0;
        en_prev_q <= 1'b0;
`ifdef MULTI_STROBE_TIMER_SHADOW_EN
        shadow_period_q <= DEFAULT_PERIOD;
        shadow_mode_q   <= DEFAULT_MODE;
        pend_q          <= 1'b0;
`endif
      end else begin
        cnt_q     <= cnt_d;
        period_q  <= period_d;
        mode_q    <= mode_d;
        out_q     <= out_d;
        tick_q    <= tick_d;
        done_q    <= done_d;
        en_prev_q <= i_en[gi];
`ifdef MULTI_STROBE_TIMER_SHADOW_EN
        shadow_period_q <= shadow_period_d;
        shadow_mode_q   <= shadow_mode_d;
        pend_q          <= pend_d;
`endif
      end
    end

    assign o_out[gi]  = out_q;
    assign o_tick[gi] = tick_q;
    assign o_done[gi] = done_q;
  end

endmodule

// File: tb/tb_multi_strobe_timer.sv
// ---------------------------------------------------------------------------
// tb_multi_strobe_timer
//   Directed bench for multi_strobe_timer with NUM_CH=3 (so index 3 is out
//   of range), CNT_W=8 and DEFAULT_PERIOD=20. Inputs change 1 time unit after
//   a rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_multi_strobe_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic       wr_stb;
  logic [1:0] wr_ch;
  logic [7:0] wr_period;
  logic [1:0] wr_mode;
  logic [2:0] out;
  logic [2:0] tick;
  logic [2:0] done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_strobe_timer #(
    .NUM_CH(3),
    .CNT_W(8),
    .DEFAULT_PERIOD(8'd20),
    .DEFAULT_MODE(2'd0)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_en(en),
    .i_wr_stb(wr_stb),
    .i_wr_ch(wr_ch),
    .i_wr_period(wr_period),
    .i_wr_mode(wr_mode),
    .o_out(out),
    .o_tick(tick),
    .o_done(done)
  );

  typedef struct {
    logic [2:0] en;
    logic       stb;
    logic [1:0] ch;
    logic [7:0] per;
    logic [1:0] mode;
    logic [2:0] out;
    logic [2:0] tick;
    logic [2:0] done;
  } vec_t;

  vec_t tbl[19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] per, input logic [1:0] mode);
    wr_stb    = 1'b1;
    wr_ch     = ch;
    wr_period = per;
    wr_mode   = mode;
  endtask

  initial begin
    // en, stb, ch, P, mode, exp out, exp tick, exp done
    tbl[0]  = '{3'b000, 1'b1, 2'd0, 8'd3, 2'd0, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b000, 3'b000, 3'b000};
    tbl[3]  = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b000, 3'b000, 3'b000};
    tbl[4]  = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b001, 3'b001, 3'b000};
    tbl[5]  = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b001, 3'b000, 3'b000};
    tbl[6]  = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b001, 3'b000, 3'b000};
    tbl[7]  = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b001, 3'b000, 3'b000};
    tbl[8]  = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b000, 3'b001, 3'b000};
    tbl[9]  = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b000, 3'b000, 3'b000};
    tbl[10] = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b000, 3'b000, 3'b000};
    tbl[11] = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b000, 3'b000, 3'b000};
    tbl[12] = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b001, 3'b001, 3'b000};
    tbl[13] = '{3'b001, 1'b1, 2'd1, 8'd0, 2'd1, 3'b001, 3'b000, 3'b000};
    tbl[14] = '{3'b011, 1'b0, 2'd0, 8'd0, 2'd0, 3'b011, 3'b010, 3'b000};
    tbl[15] = '{3'b011, 1'b0, 2'd0, 8'd0, 2'd0, 3'b011, 3'b010, 3'b000};
    tbl[16] = '{3'b011, 1'b0, 2'd0, 8'd0, 2'd0, 3'b010, 3'b011, 3'b000};
    tbl[17] = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b000, 3'b000, 3'b000};
    tbl[18] = '{3'b001, 1'b0, 2'd0, 8'd0, 2'd0, 3'b000, 3'b000, 3'b000};

    rst_n     = 1'b0;
    en        = 3'b000;
    wr_stb    = 1'b0;
    wr_ch     = 2'd0;
    wr_period = 8'd0;
    wr_mode   = 2'd0;

    // Reset state
    step();
    step();
    check("rst out", out, 3'b000);
    check("rst tick", tick, 3'b000);
    check("rst done", done, 3'b000);
    #3 rst_n = 1'b1;

    // ch0 toggle P=3, then ch1 pulse P=0 and its disable
    for (int i = 0; i < 19; i++) begin
      en        = tbl[i].en;
      wr_stb    = tbl[i].stb;
      wr_ch     = tbl[i].ch;
      wr_period = tbl[i].per;
      wr_mode   = tbl[i].mode;
      step();
      check($sformatf("vec%0d out", i), out, tbl[i].out);
      check($sformatf("vec%0d tick", i), tick, tbl[i].tick);
      check($sformatf("vec%0d done", i), done, tbl[i].done);
    end
    wr_stb = 1'b0;

    // ch2 one-shot P=5: {tick,out,done} of ch2
    en = 3'b100;
    write(2'd2, 8'd5, 2'd2);
    step();
    wr_stb = 1'b0;
    check("os wr", {tick[2], out[2], done[2]}, 3'b000);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("os1 k%0d", k), {tick[2], out[2], done[2]}, (k == 6) ? 3'b111 : 3'b000);
    end
    for (int k = 1; k <= 100; k++) begin
      step();
      check($sformatf("os hold k%0d", k), {tick[2], out[2], done[2]}, 3'b011);
    end
    en = 3'b000;
    step();
    check("os en low", {tick[2], out[2], done[2]}, 3'b011);
    en = 3'b100;
    step();
    check("os rearm", {tick[2], out[2], done[2]}, 3'b000);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("os2 k%0d", k), {tick[2], out[2], done[2]}, (k == 6) ? 3'b111 : 3'b000);
    end

    // Write colliding with a terminal on ch0
    en = 3'b101;
    write(2'd0, 8'd3, 2'd0);
    step();
    wr_stb = 1'b0;
    check("col wr", {tick[0], out[0], done[0]}, 3'b000);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("col pre k%0d", k), {tick[0], out[0], done[0]}, 3'b000);
    end
    write(2'd0, 8'd7, 2'd0);
    step();
    wr_stb = 1'b0;
    check("col term", {tick[0], out[0], done[0]}, 3'b000);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("col post k%0d", k), {tick[0], out[0], done[0]}, (k == 8) ? 3'b110 : 3'b000);
    end

    // Out-of-range channel write
    en = 3'b100;
    step();
    check("oor pre out", out, 3'b101);
    check("oor pre tick", tick, 3'b000);
    check("oor pre done", done, 3'b100);
    write(2'd3, 8'd1, 2'd2);
    step();
    wr_stb = 1'b0;
    check("oor out", out, 3'b101);
    check("oor tick", tick, 3'b000);
    check("oor done", done, 3'b100);
    en = 3'b111;
    for (int j = 1; j <= 8; j++) begin
      step();
      check($sformatf("oor run%0d out", j), out, {2'b11, j != 8});
      check($sformatf("oor run%0d tick", j), tick, {2'b01, j == 8});
      check($sformatf("oor run%0d done", j), done, 3'b100);
    end

    // Full-width period: P = 2^8-1 in pulse mode
    en = 3'b001;
    write(2'd0, 8'd255, 2'd1);
    step();
    wr_stb = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      step();
      check($sformatf("wide k%0d", k), {1'b0, out[0], tick[0]}, (k == 256) ? 3'b011 : 3'b000);
    end

    // Asynchronous reset between edges, then default period 20
    step();
    rst_n = 1'b0;
    #2;
    check("arst out", out, 3'b000);
    check("arst tick", tick, 3'b000);
    check("arst done", done, 3'b000);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      check($sformatf("dflt k%0d", k), {1'b0, out[0], tick[0]}, (k == 21) ? 3'b011 : 3'b000);
    end

`ifdef MULTI_STROBE_TIMER_SHADOW_EN
    // Shadowed period change: current 4-cycle period finishes, then 10
    en = 3'b000;
    write(2'd0, 8'd3, 2'd0);
    step();
    wr_stb = 1'b0;
    step();
    en = 3'b001;
    for (int k = 1; k <= 24; k++) begin
      if (k == 2) write(2'd0, 8'd9, 2'd0);
      step();
      wr_stb = 1'b0;
      check($sformatf("shadow k%0d", k), {2'b00, tick[0]},
            {2'b00, (k == 4) || (k == 14) || (k == 24)});
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_strobe_timer.md
Name: multi_strobe_timer

Overview:
- Parametrised successor to the single-output strobe divider. Generates NUM_CH independent strobe channels from one clock.
- Each channel has a runtime-programmable period and a mode: toggle, single-cycle pulse, or one-shot.
- Sits beside the softcore as the shared timebase for DE2 peripherals: LED blink, polling ticks, watchdog-style delays.
- Period and mode are written through a simple strobe-qualified write port.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 32, counter and period width in bits.
- DEFAULT_PERIOD, 50_000_000, period loaded into every channel at reset.
- DEFAULT_MODE, 0, mode loaded into every channel at reset (0 toggle, 1 pulse, 2 one-shot).

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_en  in  NUM_CH  per-channel run enable.
- i_wr_stb  in  1  write strobe; samples the three i_wr_* buses below.
- i_wr_ch  in  max(1,$clog2(NUM_CH))  channel index for the write.
- i_wr_period  in  CNT_W  new period value P.
- i_wr_mode  in  2  new mode.
- o_out  out  NUM_CH  per-channel strobe output.
- o_tick  out  NUM_CH  one-cycle pulse at each terminal count.
- o_done  out  NUM_CH  sticky one-shot completion flag.

Behaviour:
- Reset (async assert, sync-free release):
  - all counters 0; period = DEFAULT_PERIOD; mode = DEFAULT_MODE.
  - o_out, o_tick and o_done all 0.
- Counting: per channel, enabled and not stopped:
  - counter increments each cycle; terminal when counter == P.
  - at terminal, counter <= 0. A terminal therefore occurs every P+1 cycles.
  - P = 0 gives a terminal every cycle.
- o_tick: registered; high exactly for the cycle after the counter reaches P.
- Mode 0, toggle: o_out inverts at each terminal (same cycle o_tick rises). Square wave, period 2(P+1).
- Mode 1, pulse: o_out equals o_tick.
- Mode 2, one-shot:
  - at first terminal, o_out <= 1, o_done <= 1, and o_tick pulses once.
  - the channel then stops: counter holds at 0 and o_out stays 1.
  - re-armed by a write to the channel or by a rising edge on i_en[ch]. Re-arm clears o_done and o_out.
- Mode 3: reserved; the channel behaves as mode 0.
- i_en[ch] low:
  - counter held at 0; o_tick 0.
  - o_out holds its level in mode 0; forced 0 in mode 1; held in mode 2.
  - o_done holds.
- Write (i_wr_stb high, i_wr_ch < NUM_CH):
  - next cycle: period and mode updated, counter <= 0, o_out <= 0, o_tick <= 0, o_done <= 0.
  - applies even while enabled; the new period is counted from zero.
- Write with i_wr_ch >= NUM_CH: ignored.
- Write and terminal in the same cycle on the same channel: the write wins; no o_tick is emitted.
- Writes to other channels never disturb a channel.
- Counter width: CNT_W. A period of 2^CNT_W-1 must work with no wrap before terminal.
- Mid-operation reset: immediate return to reset values regardless of clock.

Optional Feature:
- Macro: MULTI_STROBE_TIMER_SHADOW_EN.
- When defined, a write lands in a per-channel shadow register plus a pending bit.
  - outputs and counter are not disturbed.
  - on the channel's next terminal (or immediately if the channel is disabled or stopped), the shadow is copied to active, the pending bit clears, and counting continues from 0.
  - this gives glitch-free period changes.
  - a second write before the transfer overwrites the shadow.
- When undefined, writes take effect immediately as above; no shadow storage is synthesised.

Test Plan:
- Reset release, then write ch0 P=3 mode 0, i_en=4'b0001:
  - o_tick[0] pulses every 4 cycles.
  - o_out[0] toggles every 4 cycles (period 8).
  - other channels stay quiet.
- Write ch1 P=0 mode 1, enable:
  - o_tick[1] and o_out[1] are high every cycle.
  - drop i_en[1]: both go 0 the next cycle.
- Write ch2 P=5 mode 2, enable:
  - exactly one o_tick[2] pulse, 6 cycles after the write takes effect.
  - o_out[2] and o_done[2] are then held 1 for 100 further cycles.
  - toggling i_en[2] low then high re-arms: o_done clears and a second pulse follows 6 cycles later.
- Simultaneous write and terminal on ch0 (P=3, write P=7 on the terminal cycle):
  - no tick in that cycle.
  - next tick 8 cycles later.
- Write to i_wr_ch=NUM_CH (out of range): no state change on any channel.
- Assert i_rst_n low between clock edges mid-count: all outputs 0 immediately; DEFAULT_PERIOD is restored. With MULTI_STROBE_TIMER_SHADOW_EN defined:
  - write P=9 mid-period of P=3 on ch0.
  - the current 4-cycle period completes, then 10-cycle periods follow.
